// File: rtl/ppu_blit.sv
// ppu_blit: 1-bit-per-pixel sprite blitter and screen clear engine.
// Sprite bytes are XORed into a row-major framebuffer in RAM. Each sprite byte
// straddles two framebuffer bytes (fb0 at the origin column, fb1 one column to
// the right). Any set pixel that gets cleared raises the collision flag.
module ppu_blit #(
   parameter int unsigned       ADDR_W  = 12,
   parameter int unsigned       DISP_W  = 64,
   parameter int unsigned       DISP_H  = 32,
   parameter logic [ADDR_W-1:0] FB_BASE = 'hF00,
   parameter int unsigned       WRAP    = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              draw,
   input  logic              clear,
   input  logic [ADDR_W-1:0] address,
   input  logic [3:0]        sprite_height,
   input  logic              wide,
   input  logic [7:0]        x,
   input  logic [7:0]        y,
   output logic              busy,
   output logic              done,
   output logic              collision,
   output logic [ADDR_W-1:0] mem_read_address,
   output logic              mem_read_enable,
   input  logic [7:0]        mem_read_data,
   output logic [ADDR_W-1:0] mem_write_address,
   output logic [7:0]        mem_write_data,
   output logic              mem_write_enable
);

   localparam int unsigned BPR     = DISP_W / 8;      // framebuffer bytes per row
   localparam int unsigned CW      = $clog2(BPR);
   localparam int unsigned RW      = $clog2(DISP_H);
   localparam int unsigned XW      = $clog2(DISP_W);
   localparam int unsigned RSW     = RW + 5;          // room for origin row + 15
   localparam int unsigned CSW     = CW + 2;          // room for column + 2
   localparam bit          WRAP_EN = (WRAP != 0);

   typedef enum logic [3:0] {
      ST_IDLE, ST_CLEAR,
      ST_S0, ST_S1, ST_S2, ST_S3, ST_S4, ST_S5, ST_S6, ST_S7,
      ST_DONE
   } state_t;

   state_t              state_q, state_d;
   logic [CW-1:0]       xb_q;
   logic [2:0]          sh_q;
   logic [RW-1:0]       yo_q;
   logic [ADDR_W-1:0]   addr_q;
   logic [3:0]          n_q;
   logic                wide16_q;
   logic [4:0]          k_q;
   logic [7:0]          spr_q;
   logic [7:0]          old_q;
   logic                collision_q;
   logic [RW+CW-1:0]    clr_q;

   logic                accept;
   logic [4:0]          last_k;
   logic [3:0]          rowidx;
   logic                coloff;
   logic [RSW-1:0]      row_sum;
   logic [CSW-1:0]      col0_sum;
   logic [CSW-1:0]      col1_sum;
   logic                row_ok;
   logic                do0;
   logic                do1;
   logic [ADDR_W-1:0]   fb0_addr;
   logic [ADDR_W-1:0]   fb1_addr;
   logic [ADDR_W-1:0]   spr_addr;
   logic [15:0]         part;
   logic                unused_bits;

   // Upper origin bits are discarded by the modulo reduction.
   assign unused_bits = ^{x, y};

   assign accept = (state_q == ST_IDLE) && (clear || draw);

   // Per-byte geometry: row/column of the current sprite byte and clip decisions.
   always_comb begin
      last_k   = wide16_q ? 5'd31 : ({1'b0, n_q} - 5'd1);
      rowidx   = wide16_q ? k_q[4:1] : k_q[3:0];
      coloff   = wide16_q & k_q[0];
      row_sum  = RSW'(yo_q) + RSW'(rowidx);
      col0_sum = CSW'(xb_q) + CSW'(coloff);
      col1_sum = col0_sum + CSW'(1);
      row_ok   = WRAP_EN || (row_sum < RSW'(DISP_H));
      do0      = row_ok && (WRAP_EN || (col0_sum < CSW'(BPR)));
      do1      = row_ok && (WRAP_EN || (col1_sum < CSW'(BPR)));
      fb0_addr = FB_BASE + ADDR_W'({row_sum[RW-1:0], col0_sum[CW-1:0]});
      fb1_addr = FB_BASE + ADDR_W'({row_sum[RW-1:0], col1_sum[CW-1:0]});
      spr_addr = addr_q + ADDR_W'(k_q);
      // Upper byte is the fb0 part (spr>>sh), lower byte the fb1 part.
      part     = {spr_q, 8'h00} >> sh_q;
   end

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= ST_IDLE;
      else       state_q <= state_d;
   end

   // Next-state logic and memory port drive.
   always_comb begin
      state_d           = state_q;
      mem_read_enable   = 1'b0;
      mem_read_address  = '0;
      mem_write_enable  = 1'b0;
      mem_write_address = '0;
      mem_write_data    = '0;
      case (state_q)
         ST_IDLE: begin
            if (clear)
               state_d = ST_CLEAR;
            else if (draw)
               state_d = (wide || (sprite_height != 4'd0)) ? ST_S0 : ST_DONE;
         end
         ST_CLEAR: begin
            mem_write_enable  = 1'b1;
            mem_write_address = FB_BASE + ADDR_W'(clr_q);
            if (clr_q == '1) state_d = ST_DONE;
         end
         ST_S0: begin
            mem_read_enable  = row_ok;
            mem_read_address = row_ok ? spr_addr : '0;
            state_d          = ST_S1;
         end
         ST_S1: state_d = ST_S2;
         ST_S2: begin
            mem_read_enable  = do0;
            mem_read_address = do0 ? fb0_addr : '0;
            state_d          = ST_S3;
         end
         ST_S3: state_d = ST_S4;
         ST_S4: begin
            mem_write_enable  = do0;
            mem_write_address = do0 ? fb0_addr : '0;
            mem_write_data    = do0 ? (old_q ^ part[15:8]) : '0;
            state_d           = ST_S5;
         end
         ST_S5: begin
            mem_read_enable  = do1;
            mem_read_address = do1 ? fb1_addr : '0;
            state_d          = ST_S6;
         end
         ST_S6: state_d = ST_S7;
         ST_S7: begin
            mem_write_enable  = do1;
            mem_write_address = do1 ? fb1_addr : '0;
            mem_write_data    = do1 ? (old_q ^ part[7:0]) : '0;
            state_d           = (k_q == last_k) ? ST_DONE : ST_S0;
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // Command latch, byte/clear counters, read-data capture and collision tracking.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         xb_q        <= '0;
         sh_q        <= '0;
         yo_q        <= '0;
         addr_q      <= '0;
         n_q         <= '0;
         wide16_q    <= 1'b0;
         k_q         <= '0;
         spr_q       <= '0;
         old_q       <= '0;
         collision_q <= 1'b0;
         clr_q       <= '0;
      end else begin
         if (accept) begin
            xb_q        <= x[XW-1:3];
            sh_q        <= x[2:0];
            yo_q        <= y[RW-1:0];
            addr_q      <= address;
            n_q         <= sprite_height;
            wide16_q    <= wide && (sprite_height == 4'd0);
            k_q         <= '0;
            clr_q       <= '0;
            collision_q <= 1'b0;
         end
         case (state_q)
            ST_CLEAR: clr_q <= clr_q + 1'b1;
            ST_S1:    spr_q <= mem_read_data;
            ST_S3:    old_q <= mem_read_data;
            ST_S6:    old_q <= mem_read_data;
            ST_S4: if (do0 && ((old_q & part[15:8]) != 8'h00)) collision_q <= 1'b1;
            ST_S7: begin
               if (do1 && ((old_q & part[7:0]) != 8'h00)) collision_q <= 1'b1;
               k_q <= k_q + 5'd1;
            end
            default: ;
         endcase
      end
   end

   assign busy      = (state_q != ST_IDLE);
   assign done      = (state_q == ST_DONE);
   assign collision = collision_q;

endmodule

// File: doc/ppu_blit.md
PPU_BLIT -- requirements
Module: ppu_blit

Interface
REQ-001 Parameter ADDR_W, default 12, RAM address width.
REQ-002 Parameter DISP_W, default 64, display width in pixels (power of two, >=16).
REQ-003 Parameter DISP_H, default 32, display height in pixels (power of two).
REQ-004 Parameter FB_BASE, default 'hF00, framebuffer base address; 1 bit/pixel, row-major, DISP_W/8 bytes/row, MSB = leftmost pixel.
REQ-005 Parameter WRAP, default 1: 1 = wrap at display edges, 0 = clip.
REQ-006 clk  in  1  single clock, rising edge.
REQ-007 reset  in  1  asynchronous, active-high.
REQ-008 draw  in  1  draw command strobe.
REQ-009 clear  in  1  clear-screen command strobe.
REQ-010 address  in  ADDR_W  sprite base address (I).
REQ-011 sprite_height  in  4  rows (n).
REQ-012 wide  in  1  SUPER-CHIP 16x16 sprite select when sprite_height==0.
REQ-013 x, y  in  8 each  sprite origin.
REQ-014 busy  out  1  command in progress.
REQ-015 done  out  1  one-cycle completion pulse.
REQ-016 collision  out  1  any set pixel was cleared by the last draw.
REQ-017 mem_read_address / mem_read_enable / mem_read_data  out ADDR_W / out 1 / in 8; synchronous RAM, data valid one cycle after enable.
REQ-018 mem_write_address / mem_write_data / mem_write_enable  out ADDR_W / out 8 / out 1.

Function
REQ-019 Commands are sampled only in IDLE; draw/clear while busy is ignored; clear wins when both are high.
REQ-020 On accept: busy=1 from the next cycle, collision cleared to 0, x/y/address/height/wide latched.
REQ-021 Origin reduced modulo DISP_W and DISP_H before use; xb=x/8, sh=x%8.
REQ-022 Byte list: rows R=sprite_height, 1 byte/row; if wide and sprite_height==0, R=16, 2 bytes/row (second byte at column x+8); sprite byte k read from (address+k) mod 2^ADDR_W.
REQ-023 sprite_height==0 with wide==0: no memory access, go straight to DONE, collision 0.
REQ-024 Per sprite byte, exactly 8 cycles: S0 issue sprite read; S1 latch; S2 issue read fb0; S3 latch; S4 write fb0 = old ^ (spr>>sh); S5 issue read fb1; S6 latch; S7 write fb1 = old ^ (spr<<(8-sh))[7:0].
REQ-025 fb address = FB_BASE + row*(DISP_W/8) + col; fb1 col = col+1.
REQ-026 WRAP=1: col wraps modulo DISP_W/8 within the same row; row wraps modulo DISP_H.
REQ-027 WRAP=0: fb1 past right edge -> S5-S7 no read/write; row >= DISP_H -> that byte performs no read/write; cycle count unchanged.
REQ-028 sh==0: fb1 still read and rewritten unchanged (XOR with 0).
REQ-029 collision set if (old & sprite-part)!=0 on any performed write; held until next accepted command.
REQ-030 Clear: one write of 0x00 per cycle to all DISP_W*DISP_H/8 framebuffer bytes in ascending order, no reads.
REQ-031 DONE: one cycle, done=1, busy=1; next cycle IDLE, busy=0, done=0.
REQ-032 Latency: draw busy for 8*B+1 cycles (B = bytes drawn); clear busy for DISP_W*DISP_H/8+1 cycles.
REQ-033 States: IDLE, CLEAR, S0..S7, DONE; mem_read_enable high only in S0/S2/S5; mem_write_enable high only in CLEAR/S4/S7.

Reset
REQ-034 reset asserted: state IDLE, busy=0, done=0, collision=0, both enables 0, addresses/data 0, regardless of command in progress.
REQ-035 Framebuffer writes already performed before a mid-operation reset are not undone; first command after release is accepted normally.

Verification
REQ-036 clear -> 257 busy cycles, 'hF00..'hFFF read 0x00, collision=0, one done pulse.
REQ-037 After clear, draw x=12,y=8,n=15,address='h22A -> busy 121 cycles, row 8 bytes at 'hF41/'hF42 = spr>>4 / spr<<4, collision=0.
REQ-038 Repeat identical draw -> collision=1, framebuffer all 0x00 again.
REQ-039 Sprite 0xFF at x=60,y=0,n=1: WRAP=1 -> 'hF07=0x0F, 'hF00=0xF0; WRAP=0 -> 'hF00 untouched, no write issued in S7.
REQ-040 y=31,n=2,WRAP=1 -> second row written in row 0; wide=1,n=0 -> 32 bytes, busy 257 cycles; reset asserted at cycle 20 of a draw -> busy=0, enables 0 immediately, next draw completes normally.
